// File: rtl/ir_dec_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ir_dec_stage (with package ir_dec_pkg)
//  Brief    : RV32I/RV32M decode pipeline stage between fetch and execute.
//             Instructions are decoded as they are written into a 2-entry
//             skid buffer; the head entry drives the outputs. Valid/ready on
//             both sides, synchronous flush, illegal-instruction detection.
//  Revision : 1.0 - initial release
// ============================================================================

package ir_dec_pkg;

  // Decoded control bundle handed to execute.
  typedef struct packed {
    logic       w;                     // writes rd
    logic       ignore_first_operand;  // operand A forced to zero (LUI)
    logic       j;                     // jump (JAL/JALR)
    logic       b;                     // conditional branch
    logic       l;                     // load
    logic       s;                     // store
    logic       wb_src;                // write-back from memory
    logic       m;                     // RV32M multiply/divide
    logic       sign;                  // SUB, or sign-extending load
    logic [1:0] dw;                    // memory access width (func3[1:0])
  } control_signals_t;

endpackage

module ir_dec_stage
  import ir_dec_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit ENABLE_M   = 1'b1,
  parameter bit ENABLE_SYS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ir,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output control_signals_t cs,
  output logic [1:0]       alu_src_sel,
  output logic [XLEN-1:0]  imm,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [2:0]       func3,
  output logic [XLEN-1:0]  out_pc,
  output logic             illegal,
  output logic             ecall,
  output logic             ebreak,
  output logic             fence
);

  // --------------------------------------------------------------------------
  // Encoding constants
  // --------------------------------------------------------------------------
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] c_IR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] c_IR_EBREAK = 32'h0010_0073;

  localparam logic [1:0] c_SEL_NONE = 2'b00;
  localparam logic [1:0] c_SEL_IMMI = 2'b10;
  localparam logic [1:0] c_SEL_IMMU = 2'b11;

  // One buffered, already-decoded instruction.
  typedef struct packed {
    control_signals_t cs;
    logic [1:0]       alu_src_sel;
    logic [XLEN-1:0]  imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [2:0]       func3;
    logic [XLEN-1:0]  pc;
    logic             illegal;
    logic             ecall;
    logic             ebreak;
    logic             fence;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Field extraction and immediates (sign-extended to XLEN by cast)
  // --------------------------------------------------------------------------
  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic            w_slli_ok;
  logic            w_sri_ok;

  assign w_opc   = in_ir[6:0];
  assign w_f3    = in_ir[14:12];
  assign w_f7    = in_ir[31:25];
  assign w_imm_i = XLEN'($signed(in_ir[31:20]));
  assign w_imm_s = XLEN'($signed({in_ir[31:25], in_ir[11:7]}));
  assign w_imm_b = XLEN'($signed({in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({in_ir[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0}));

  // Shift-immediate upper-bit checks; with XLEN=64 ir[25] belongs to shamt.
  generate
    if (XLEN == 64) begin : g_shamt6
      assign w_slli_ok = (in_ir[31:26] == 6'b000000);
      assign w_sri_ok  = (in_ir[31:26] == 6'b000000) || (in_ir[31:26] == 6'b010000);
    end else begin : g_shamt5
      assign w_slli_ok = (in_ir[31:25] == 7'b0000000);
      assign w_sri_ok  = (in_ir[31:25] == 7'b0000000) || (in_ir[31:25] == 7'b0100000);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Decoder
  // --------------------------------------------------------------------------
  entry_t w_dec;
  logic   w_ill;

  // Decode the incoming word into a buffer entry; illegal words are scrubbed.
  always_comb begin
    w_dec             = '0;
    w_ill             = 1'b0;
    w_dec.rs1         = in_ir[19:15];
    w_dec.rs2         = in_ir[24:20];
    w_dec.rd          = in_ir[11:7];
    w_dec.func3       = w_f3;
    w_dec.pc          = in_pc;
    w_dec.alu_src_sel = c_SEL_NONE;

    case (w_opc)
      c_OPC_LUI: begin
        w_dec.cs.w                    = 1'b1;
        w_dec.cs.ignore_first_operand = 1'b1;
        w_dec.alu_src_sel             = c_SEL_IMMU;
        w_dec.imm                     = w_imm_u;
      end
      c_OPC_AUIPC: begin
        w_dec.cs.w        = 1'b1;
        w_dec.alu_src_sel = c_SEL_IMMU;
        w_dec.imm         = w_imm_u;
      end
      c_OPC_JAL: begin
        w_dec.cs.w        = 1'b1;
        w_dec.cs.j        = 1'b1;
        w_dec.alu_src_sel = c_SEL_IMMU;
        w_dec.imm         = w_imm_j;
      end
      c_OPC_JALR: begin
        w_dec.cs.w        = 1'b1;
        w_dec.cs.j        = 1'b1;
        w_dec.alu_src_sel = c_SEL_IMMI;
        w_dec.imm         = w_imm_i;
      end
      c_OPC_BRANCH: begin
        w_dec.cs.b = 1'b1;
        w_dec.imm  = w_imm_b;
        if (w_f3 == 3'b010 || w_f3 == 3'b011) w_ill = 1'b1;
      end
      c_OPC_LOAD: begin
        w_dec.cs.l        = 1'b1;
        w_dec.cs.w        = 1'b1;
        w_dec.cs.wb_src   = 1'b1;
        w_dec.cs.dw       = w_f3[1:0];
        w_dec.cs.sign     = ~w_f3[2];
        w_dec.alu_src_sel = c_SEL_IMMI;
        w_dec.imm         = w_imm_i;
        if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) w_ill = 1'b1;
      end
      c_OPC_STORE: begin
        w_dec.cs.s  = 1'b1;
        w_dec.cs.dw = w_f3[1:0];
        w_dec.imm   = w_imm_s;
        if (w_f3 > 3'b010) w_ill = 1'b1;
      end
      c_OPC_OPIMM: begin
        w_dec.cs.w        = 1'b1;
        w_dec.alu_src_sel = c_SEL_IMMI;
        w_dec.imm         = w_imm_i;
        if (w_f3 == 3'b001 && !w_slli_ok) w_ill = 1'b1;
        if (w_f3 == 3'b101 && !w_sri_ok)  w_ill = 1'b1;
      end
      c_OPC_OP: begin
        if (w_f7 == 7'b0000001) begin
          if (ENABLE_M) begin
            w_dec.cs.w = 1'b1;
            w_dec.cs.m = 1'b1;
          end else begin
            w_ill = 1'b1;
          end
        end else if (w_f7 == 7'b0000000) begin
          w_dec.cs.w = 1'b1;
        end else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
          // SUB and SRA; only SUB flags a signed (subtracting) operation
          w_dec.cs.w    = 1'b1;
          w_dec.cs.sign = (w_f3 == 3'b000);
        end else begin
          w_ill = 1'b1;
        end
      end
      c_OPC_FENCE: begin
        if (ENABLE_SYS && w_f3 == 3'b000) w_dec.fence = 1'b1;
        else                              w_ill       = 1'b1;
      end
      c_OPC_SYSTEM: begin
        if (ENABLE_SYS && in_ir == c_IR_ECALL)       w_dec.ecall  = 1'b1;
        else if (ENABLE_SYS && in_ir == c_IR_EBREAK) w_dec.ebreak = 1'b1;
        else                                         w_ill        = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase

    // Illegal words keep only raw register fields, func3 and PC.
    if (w_ill) begin
      w_dec.cs          = '0;
      w_dec.imm         = '0;
      w_dec.alu_src_sel = c_SEL_NONE;
      w_dec.ecall       = 1'b0;
      w_dec.ebreak      = 1'b0;
      w_dec.fence       = 1'b0;
      w_dec.illegal     = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Skid buffer and occupancy FSM
  // --------------------------------------------------------------------------
  state_t r_state;
  logic   r_in_ready;
  entry_t r_head;
  entry_t r_tail;
  logic   w_accept;
  logic   w_emit;

  assign w_accept = in_valid & r_in_ready;
  assign w_emit   = (r_state != S_EMPTY) & out_ready;

  // Occupancy state, buffered entries and registered in_ready; flush wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (flush) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= 1'b1;
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_head  <= w_dec;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && !w_emit) begin
            r_tail     <= w_dec;
            r_state    <= S_TWO;
            r_in_ready <= 1'b0;
          end else if (w_accept && w_emit) begin
            r_head <= w_dec;
          end else if (w_emit) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_emit) begin
            r_head  <= r_tail;
            r_state <= S_ONE;
          end else begin
            r_in_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: handshake from state, payload from the head entry
  // --------------------------------------------------------------------------
  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != S_EMPTY);
  assign cs          = r_head.cs;
  assign alu_src_sel = r_head.alu_src_sel;
  assign imm         = r_head.imm;
  assign rs1         = r_head.rs1;
  assign rs2         = r_head.rs2;
  assign rd          = r_head.rd;
  assign func3       = r_head.func3;
  assign out_pc      = r_head.pc;
  assign illegal     = r_head.illegal;
  assign ecall       = r_head.ecall;
  assign ebreak      = r_head.ebreak;
  assign fence       = r_head.fence;

endmodule

`default_nettype wire

// File: tb/tb_ir_dec_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ir_dec_stage
//  Brief    : Scoreboard bench for ir_dec_stage. A second instance with
//             RV32M and SYSTEM/FENCE disabled shares all inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ir_dec_stage;
  import ir_dec_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_ir = '0;
  logic [31:0] in_pc = '0;

  logic             in_ready, out_valid, illegal, ecall, ebreak, fence;
  control_signals_t cs;
  logic [1:0]       alu_src_sel;
  logic [31:0]      imm, out_pc;
  logic [4:0]       rs1, rs2, rd;
  logic [2:0]       func3;

  logic             n_in_ready, n_out_valid, n_illegal, n_ecall, n_ebreak, n_fence;
  control_signals_t n_cs;
  logic [1:0]       n_sel;
  logic [31:0]      n_imm, n_pc;
  logic [4:0]       n_rs1, n_rs2, n_rd;
  logic [2:0]       n_func3;

  ir_dec_stage #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_SYS(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .cs(cs), .alu_src_sel(alu_src_sel), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func3(func3), .out_pc(out_pc), .illegal(illegal), .ecall(ecall),
    .ebreak(ebreak), .fence(fence)
  );

  ir_dec_stage #(.XLEN(32), .ENABLE_M(1'b0), .ENABLE_SYS(1'b0)) dut_nom (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_ir(in_ir),
    .in_pc(in_pc), .flush(flush), .out_valid(n_out_valid), .out_ready(out_ready),
    .cs(n_cs), .alu_src_sel(n_sel), .imm(n_imm), .rs1(n_rs1), .rs2(n_rs2), .rd(n_rd),
    .func3(n_func3), .out_pc(n_pc), .illegal(n_illegal), .ecall(n_ecall),
    .ebreak(n_ebreak), .fence(n_fence)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      ir;
    logic [31:0]      pc;
    control_signals_t cs;
    logic [1:0]       sel;
    logic [31:0]      imm;
    logic [3:0]       flg;   // {illegal, ecall, ebreak, fence}
    logic             nom;   // illegal flag expected from the M/SYS-disabled instance
  } exp_t;

  exp_t sb[$];
  exp_t vecs[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic control_signals_t mkcs(input logic w, ifo, j, b, l, s, wb, m, sg,
                                            input logic [1:0] dw);
    control_signals_t c;
    c.w = w; c.ignore_first_operand = ifo; c.j = j; c.b = b; c.l = l; c.s = s;
    c.wb_src = wb; c.m = m; c.sign = sg; c.dw = dw;
    return c;
  endfunction

  function automatic exp_t mk(input logic [31:0] ir, input control_signals_t c,
                              input logic [1:0] sel, input logic [31:0] im,
                              input logic [3:0] flg, input logic nom);
    exp_t e;
    e.ir = ir; e.pc = '0; e.cs = c; e.sel = sel; e.imm = im; e.flg = flg; e.nom = nom;
    return e;
  endfunction

  // Issue one instruction; the expected entry is queued when the handshake will occur.
  task automatic send(input exp_t e, input logic [31:0] pc);
    exp_t x = e;
    x.pc     = pc;
    in_valid = 1'b1;
    in_ir    = e.ir;
    in_pc    = pc;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL send_timeout: in_ready stayed %0b for ir %08h, required 1", in_ready, e.ir);
    in_valid = 1'b0;
  endtask

  task automatic drain_check(input string name);
    repeat (4) @(posedge clk);
    #1;
    check(name, sb.size(), 0);
  endtask

  // Monitor: compare the head entry whenever it is about to be emitted.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_emit: got pc %08h, required no output", out_pc);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("decode[%08h]", mon_e.ir),
              {cs, alu_src_sel, imm, illegal, ecall, ebreak, fence},
              {mon_e.cs, mon_e.sel, mon_e.imm, mon_e.flg});
        check($sformatf("fields[%08h]", mon_e.ir),
              {rs1, rs2, rd, func3, out_pc},
              {mon_e.ir[19:15], mon_e.ir[24:20], mon_e.ir[11:7], mon_e.ir[14:12], mon_e.pc});
        check($sformatf("illegal_noext[%08h]", mon_e.ir), {n_out_valid, n_illegal}, {1'b1, mon_e.nom});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //              ir            w ifo j b l s wb m sg dw         sel    imm           flg    nom
    vecs.push_back(mk(32'hFFF00093, mkcs(1,0,0,0,0,0,0,0,0,2'b00), 2'b10, 32'hFFFFFFFF, 4'b0000, 1'b0)); // ADDI x1,x0,-1
    vecs.push_back(mk(32'h123450B7, mkcs(1,1,0,0,0,0,0,0,0,2'b00), 2'b11, 32'h12345000, 4'b0000, 1'b0)); // LUI
    vecs.push_back(mk(32'h407302B3, mkcs(1,0,0,0,0,0,0,0,1,2'b00), 2'b00, 32'h00000000, 4'b0000, 1'b0)); // SUB
    vecs.push_back(mk(32'hFFC19103, mkcs(1,0,0,0,1,0,1,0,1,2'b01), 2'b10, 32'hFFFFFFFC, 4'b0000, 1'b0)); // LH -4
    vecs.push_back(mk(32'h00512423, mkcs(0,0,0,0,0,1,0,0,0,2'b10), 2'b00, 32'h00000008, 4'b0000, 1'b0)); // SW 8
    vecs.push_back(mk(32'hFE209CE3, mkcs(0,0,0,1,0,0,0,0,0,2'b00), 2'b00, 32'hFFFFFFF8, 4'b0000, 1'b0)); // BNE -8
    vecs.push_back(mk(32'h0100006F, mkcs(1,0,1,0,0,0,0,0,0,2'b00), 2'b11, 32'h00000010, 4'b0000, 1'b0)); // JAL 16
    vecs.push_back(mk(32'h4030D093, mkcs(1,0,0,0,0,0,0,0,0,2'b00), 2'b10, 32'h00000403, 4'b0000, 1'b0)); // SRAI
    vecs.push_back(mk(32'h0220F1B3, mkcs(1,0,0,0,0,0,0,1,0,2'b00), 2'b00, 32'h00000000, 4'b0000, 1'b1)); // REMU
    vecs.push_back(mk(32'h00000073, '0,                            2'b00, 32'h00000000, 4'b0100, 1'b1)); // ECALL
    vecs.push_back(mk(32'h00100073, '0,                            2'b00, 32'h00000000, 4'b0010, 1'b1)); // EBREAK
    vecs.push_back(mk(32'h0FF0000F, '0,                            2'b00, 32'h00000000, 4'b0001, 1'b1)); // FENCE
    vecs.push_back(mk(32'hFFFFFFFF, '0,                            2'b00, 32'h00000000, 4'b1000, 1'b1)); // bad opcode
    vecs.push_back(mk(32'h40309093, '0,                            2'b00, 32'h00000000, 4'b1000, 1'b1)); // SLLI bad func7
    vecs.push_back(mk(32'h0000B083, '0,                            2'b00, 32'h00000000, 4'b1000, 1'b1)); // load func3 011
    vecs.push_back(mk(32'h30200073, '0,                            2'b00, 32'h00000000, 4'b1000, 1'b1)); // other SYSTEM

    // Reset state
    #1;
    check("reset_handshake", {out_valid, in_ready}, 2'b00);
    check("reset_payload", {cs, alu_src_sel, imm, rd, out_pc, illegal}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", {in_ready, out_valid}, 2'b10);

    // Latency and streaming throughput with out_ready held high
    out_ready = 1'b1;
    send(vecs[0], 32'h0000_1000);
    check("latency_out_valid", out_valid, 1'b1);
    for (int i = 1; i < vecs.size(); i++) send(vecs[i], 32'h0000_1000 + 32'(4 * i));
    drain_check("stream_drained");

    // Backpressure: two accepted, third held, head stable
    out_ready = 1'b0;
    send(vecs[1], 32'h0000_2000);
    send(vecs[2], 32'h0000_2004);
    check("full_in_ready", {in_ready, out_valid}, 2'b01);
    in_valid = 1'b1;
    in_ir    = vecs[3].ir;
    in_pc    = 32'h0000_2008;
    repeat (3) @(posedge clk);
    #1;
    check("head_stable", {out_pc, imm}, {32'h0000_2000, vecs[1].imm});
    check("full_stall", {in_ready, sb.size()}, {1'b0, 32'd2});
    out_ready = 1'b1;
    send(vecs[3], 32'h0000_2008);
    drain_check("backpressure_drained");

    // Flush with a full buffer and a pending instruction
    out_ready = 1'b0;
    send(vecs[4], 32'h0000_3000);
    send(vecs[5], 32'h0000_3004);
    in_valid = 1'b1;
    in_ir    = vecs[6].ir;
    in_pc    = 32'h0000_3008;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    check("flush_empty", {out_valid, in_ready}, 2'b01);
    // Flush still high while the stage accepts: the accepted word is dropped
    @(posedge clk);
    #1;
    check("flush_discards_accept", out_valid, 1'b0);
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    send(vecs[7], 32'h0000_3100);
    drain_check("post_flush_drained");

    // Asynchronous reset in mid-cycle with a full buffer
    out_ready = 1'b0;
    send(vecs[8], 32'h0000_4000);
    send(vecs[9], 32'h0000_4004);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_handshake", {out_valid, in_ready}, 2'b00);
    check("async_reset_payload",
          {cs, alu_src_sel, imm, rs1, rs2, rd, func3, out_pc, illegal, ecall, ebreak, fence}, '0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_async_reset", {in_ready, out_valid}, 2'b10);
    out_ready = 1'b1;
    send(vecs[10], 32'h0000_5000);
    send(vecs[11], 32'h0000_5004);
    drain_check("final_drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
